// File: rtl/fft_stage_sequencer.sv
// Address/twiddle sequencer for an in-place radix-2 DIF FFT: one butterfly pair per cycle,
// write-back delayed by PIPE_LAT, and a PIPE_LAT-cycle drain between stages.
module fft_stage_sequencer #(
   parameter int POINT    = 8,
   parameter int SET      = $clog2(POINT),
   parameter int PIPE_LAT = 7
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   output logic [$clog2(SET)-1:0]  stage_idx,
   output logic                    rd_en,
   output logic [SET-1:0]          rd_addr_up,
   output logic [SET-1:0]          rd_addr_dn,
   output logic [SET-2:0]          tw_idx,
   output logic                    wr_en,
   output logic [SET-1:0]          wr_addr_up,
   output logic [SET-1:0]          wr_addr_dn
);

   localparam int SW   = $clog2(SET);
   localparam int JW   = SET - 1;
   localparam int HALF = POINT / 2;
   localparam int CW   = $clog2(PIPE_LAT) + 1;
   localparam int DW   = 2 * SET + 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t                      state;
   logic [JW-1:0]               j;
   logic [CW-1:0]               dcnt;
   logic [PIPE_LAT-1:0][DW-1:0] dly;

   logic [SW-1:0]  nxt_s;
   logic [JW-1:0]  nxt_j;
   logic [SET-1:0] jx;
   logic [SET-1:0] mask;
   logic [SET-1:0] nxt_span;
   logic [SET-1:0] nxt_up;
   logic [SET-2:0] nxt_tw;
   logic           last_j;
   logic           last_d;
   logic           last_s;
   logic           issue;
   int             shamt;

   assign last_j = (j == JW'(HALF - 1));
   assign last_d = (dcnt == CW'(PIPE_LAT - 1));
   assign last_s = (stage_idx == SW'(SET - 1));

   // A pair is issued on the edge that enters (or stays in) RUN, so the
   // address of the pair visible next cycle is computed from next-cycle counters.
   always_comb begin
      nxt_s = stage_idx;
      nxt_j = j + JW'(1);
      if (state == IDLE) begin
         nxt_s = '0;
         nxt_j = '0;
      end else if (state == DRAIN) begin
         nxt_s = last_s ? stage_idx : stage_idx + SW'(1);
         nxt_j = '0;
      end
      shamt    = SET - 1 - int'(nxt_s);
      jx       = SET'(nxt_j);
      nxt_span = SET'(1) << shamt;
      mask     = nxt_span - SET'(1);
      nxt_up   = ((jx >> shamt) << (shamt + 1)) | (jx & mask);
      nxt_tw   = JW'((jx & mask) << nxt_s);
   end

   always_comb begin
      issue = 1'b0;
      case (state)
         IDLE:    issue = start;
         RUN:     issue = !last_j;
         DRAIN:   issue = last_d && !last_s;
         default: issue = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         j          <= '0;
         stage_idx  <= '0;
         dcnt       <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         rd_en      <= 1'b0;
         rd_addr_up <= '0;
         rd_addr_dn <= '0;
         tw_idx     <= '0;
         dly        <= '0;
      end else begin
         dly[0] <= {rd_en, rd_addr_up, rd_addr_dn};
         for (int i = 1; i < PIPE_LAT; i++) begin
            dly[i] <= dly[i-1];
         end

         rd_en      <= issue;
         rd_addr_up <= issue ? nxt_up : '0;
         rd_addr_dn <= issue ? (nxt_up | nxt_span) : '0;
         tw_idx     <= issue ? nxt_tw : '0;
         done       <= 1'b0;

         case (state)
            IDLE: begin
               if (start) begin
                  state     <= RUN;
                  stage_idx <= nxt_s;
                  j         <= nxt_j;
                  busy      <= 1'b1;
               end
            end
            RUN: begin
               if (last_j) begin
                  state <= DRAIN;
                  dcnt  <= '0;
               end else begin
                  j <= nxt_j;
               end
            end
            DRAIN: begin
               if (!last_d) begin
                  dcnt <= dcnt + CW'(1);
               end else if (last_s) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  state     <= RUN;
                  stage_idx <= nxt_s;
                  j         <= nxt_j;
               end
            end
            DONE: begin
               state     <= IDLE;
               stage_idx <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Idle slots carry zero addresses, so gated write addresses come for free.
   assign {wr_en, wr_addr_up, wr_addr_dn} = dly[PIPE_LAT-1];

endmodule

// File: doc/fft_stage_sequencer.md
# fft_stage_sequencer

Sequencer for one in-place radix-2 DIF FFT over an N-point sample memory. It drives the shared butterfly datapath through all log2(POINT) stages. Per cycle it issues one read-address pair to the sample memory and one twiddle index to the twiddle lookup. It delays each address pair to match the memory-plus-butterfly latency and issues the write-back. It also inserts a pipeline drain between stages so a stage never reads data the previous stage has not yet written.

## Interface
- POINT, 8: FFT size; power of two, ≥ 4.
- SET, $clog2(POINT): address width.
- PIPE_LAT, 7: cycles from `rd_en` to the matching write-back. Equals 1 (memory read) + 6 (butterfly multiply path). Must be ≥ 1.

- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a transform when idle.
- busy  out  1  high from the cycle after an accepted `start` through the last DRAIN cycle.
- done  out  1  one-cycle pulse after the final write-back.
- stage_idx  out  $clog2(SET)  current stage, 0..SET-1.
- rd_en  out  1  read request for one butterfly pair.
- rd_addr_up  out  SET  upper-leg read address.
- rd_addr_dn  out  SET  lower-leg read address.
- tw_idx  out  SET-1  twiddle index for the issued pair; valid with `rd_en`.
- wr_en  out  1  write-back strobe.
- wr_addr_up  out  SET  destination for the butterfly sum output.
- wr_addr_dn  out  SET  destination for the twiddled difference output.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: `start`=1 → RUN, with stage=0 and pair counter j=0. `start` is ignored in every other state.
  - RUN: one `rd_en` per cycle, j = 0..POINT/2-1. At j = POINT/2-1 → DRAIN, with the drain counter cleared.
  - DRAIN: lasts exactly PIPE_LAT cycles, then:
    - if stage < SET-1: stage+1, j=0 → RUN;
    - else → DONE.
  - DONE: one cycle with `done`=1, then → IDLE.
- Address generation (DIF) for stage s:
  - L = SET-1-s; span = 2^L.
  - rd_addr_up = ((j >> L) << (L+1)) | (j & (span-1)).
  - rd_addr_dn = rd_addr_up | span.
  - tw_idx = (j & (span-1)) << s, truncated to SET-1 bits.
- Write-back delay line:
  - PIPE_LAT-deep shift register of {rd_en, rd_addr_up, rd_addr_dn}.
  - Its output drives wr_en, wr_addr_up and wr_addr_dn.
  - It shifts every cycle regardless of state.
- Output gating:
  - rd_addr_*, tw_idx are 0 whenever `rd_en`=0.
  - wr_addr_* are 0 whenever `wr_en`=0.
- Outputs are registered: no combinational path from `start` to any output.

## Timing
- Reset (async assert, value held while `rst_n`=0):
  - state=IDLE; all counters 0; delay line cleared.
  - busy=0, done=0, rd_en=0, wr_en=0, all addresses 0, tw_idx=0, stage_idx=0.
- Reset mid-transform: the transform is abandoned immediately. No further `wr_en` occurs, because the delay line is cleared. A new `start` is required.
- `start` sampled at cycle 0:
  - busy=1 and the first `rd_en` at cycle 1.
  - Stage s RUN occupies cycles 1 + s·(POINT/2+PIPE_LAT) for POINT/2 cycles.
- `wr_en` for a read issued at cycle t asserts at t+PIPE_LAT.
- The last write-back of a stage coincides with the last DRAIN cycle.
- The next stage's first read is the following cycle, so there is no read-after-write overlap between stages.
- `done` is asserted in the cycle after the final `wr_en`, with busy=0 in that same cycle.
- Total latency from `start` to `done` = SET·(POINT/2+PIPE_LAT) + 1 cycles.
- `start` asserted in the same cycle as `done`: ignored (state ≠ IDLE).
- `start` on the cycle after `done`: accepted.

## Test plan
- Reset, then idle 10 cycles with no start → all outputs 0; `start` held high while `rst_n`=0 → no activity.
- POINT=8, PIPE_LAT=7, start at cycle 0 → (up,dn,tw) sequence:
  - stage 0 (cycles 1–4): (0,4,0), (1,5,1), (2,6,2), (3,7,3);
  - stage 1 (cycles 12–15): (0,2,0), (1,3,2), (4,6,0), (5,7,2);
  - stage 2 (cycles 23–26): (0,1,0), (2,3,0), (4,5,0), (6,7,0).
- Same run → `wr_en` at cycles 8–11, 19–22 and 30–33, carrying the same address pairs; `done` pulse at cycle 34; busy high for cycles 1–33.
- `start` pulses at cycles 5 and 34 (while busy / during DONE) → ignored; the cycle-34 `done` timing is unchanged; `start` at cycle 35 → new transform, first `rd_en` at cycle 36.
- `rst_n` low at cycle 17 for 1 cycle → `rd_en` and `wr_en` both drop the same cycle, no write-back afterwards; a subsequent `start` reproduces the full cycle-accurate sequence.
- POINT=16, PIPE_LAT=1 → 4 stages of 8 reads and 1 drain cycle each, `done` 37 cycles after `start`; stage 3 tw_idx all 0, stage 0 tw_idx 0..7.
